uart_rx_framed: RTL and testbench
=================================

Name: uart_rx_framed

Overview:
Parametrised successor to the basic UART receiver. It adds:
- an input synchroniser
- mid-bit sampling with false-start rejection
- optional parity
- one or two stop bits
- parity and framing error reporting

It sits between the board RX pin and the command/weight-load path. The output handshake is the same one-cycle new_data_out pulse used by existing consumers.

Parameters:
CLK_BAUD_RATIO, 25, clock cycles per bit (R); legal >= 4, elaboration error otherwise
DATA_SIZE, 8, data bits per frame, LSB first; legal 1..16
PARITY, 0, 0 none / 1 odd / 2 even; other values are an elaboration error
STOP_BITS, 1, stop bits checked; legal 1 or 2
SYNC_STAGES, 2, flops in the rx_in synchroniser; legal >= 2

Ports:
clk_in  input  1  single system clock
rst_in  input  1  synchronous, active-high reset
rx_in  input  1  asynchronous serial line, idle high
data_out  output  DATA_SIZE  last received word, held until next completed frame
new_data_out  output  1  one-cycle pulse: data_out and error flags updated this cycle
parity_err_out  output  1  parity mismatch in last frame (0 when PARITY=0)
frame_err_out  output  1  any checked stop bit sampled 0 in last frame
busy_out  output  1  frame in progress

Behaviour:
- Reset (synchronous, rst_in high at posedge):
  - all outputs go to 0; FSM goes to IDLE; counters go to 0.
  - Synchroniser flops reset to 1, so no spurious start is detected after reset.
  - Reset mid-frame abandons the frame with no pulse.
- Sampled line: rxs = output of the SYNC_STAGES-deep synchroniser. All decisions use rxs only.
- HALF = floor(R/2). Bit counter width is $clog2(DATA_SIZE).
- FSM states:
  - IDLE: busy_out=0. In the first cycle with rxs=0, call that cycle t0: go to START, load the baud counter for HALF, set busy_out=1 from t0+1.
  - START: at t0+HALF sample rxs.
    - rxs=1: false start, back to IDLE, busy_out drops next cycle, no pulse.
    - rxs=0: go to DATA.
  - DATA: data bit i is sampled at t0+HALF+(i+1)*R, i=0..DATA_SIZE-1, and stored in bit i (LSB first). After the last bit go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample at t0+HALF+(DATA_SIZE+1)*R. Error if XOR(data, parity bit) != 1 (odd) or != 0 (even).
  - STOP: stop bit k is sampled at t0+HALF+(DATA_SIZE+1+P+k)*R, where P = (PARITY!=0) and k=0..STOP_BITS-1. Any 0 sample sets the frame error.
- Completion:
  - In the cycle after the final stop sample, all of the following happen together: new_data_out=1 for exactly one cycle; data_out, parity_err_out and frame_err_out load; busy_out=0; FSM is in IDLE.
  - Data is delivered even when an error flag is set.
  - Error flags hold until the next completed frame.
- Back-to-back frames: IDLE is entered half a bit early. A start edge arriving immediately after the stop-bit centre is accepted, with no dead time.
- Break (line held low): the frame completes with frame_err_out=1 and data_out=0. The FSM then stays in IDLE until rxs returns to 1; it does not re-trigger on the same low level.
- Latency: rx_in fall to t0 is SYNC_STAGES cycles (±1 for async phase).
  - With defaults (8N1, R=25, HALF=12), the last stop sample is at t0+237 and new_data_out is at t0+238.

Decomposition:
- Package uart_pkg holds:
  - parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2
  - the FSM state typedef rx_state_t {IDLE, START, DATA, PARITY, STOP}
- One sub-module, bit_sync (parameter STAGES, reset value 1). It is reusable by the tx side and other pin inputs.

Test Plan:
1. Defaults, send 0xA5 at R=25 → one pulse at t0+238, data_out=0xA5, both errors 0, busy_out high t0+1..t0+237.
2. Defaults, 10-cycle low glitch on idle line → START rejects at t0+12, no pulse, busy_out low by t0+13.
3. PARITY=2, send 0x07 with parity bit 0 → data_out=0x07, parity_err_out=1; resend with parity bit 1 → parity_err_out=0.
4. STOP_BITS=2, send 0x3C with second stop bit 0 → frame_err_out=1, data_out=0x3C; line held low 20 bit-times → single pulse with data_out=0x00 and frame_err_out=1, then no new frame until the line goes high.
5. Back-to-back 0x55, 0xAA with start edge immediately after stop → two pulses exactly 10*R=250 cycles apart, both correct.
6. Assert rst_in for one cycle at bit 4 of a frame → outputs 0, no pulse; the following clean frame 0x3F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and receiver FSM states.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; resets to 1.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) sync_q <= '1;
    else        sync_q <= {sync_q[STAGES-2:0], async_in};
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver with input synchroniser, mid-bit sampling, optional parity,
// one or two stop bits and parity/framing error reporting.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLK_BAUD_RATIO = 25,
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 new_data_out,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 busy_out
);

  if (CLK_BAUD_RATIO < 4) begin : g_bad_ratio
    $error("uart_rx_framed: CLK_BAUD_RATIO must be >= 4");
  end
  if (DATA_SIZE < 1 || DATA_SIZE > 16) begin : g_bad_size
    $error("uart_rx_framed: DATA_SIZE must be 1..16");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_rx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_framed: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned HALF   = CLK_BAUD_RATIO / 2;
  localparam int unsigned BAUD_W = $clog2(CLK_BAUD_RATIO);
  localparam int unsigned BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  logic rxs;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .async_in (rx_in),
    .sync_out (rxs)
  );

  rx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 wait_high_q, wait_high_d;
  logic [DATA_SIZE-1:0] data_d;
  logic                 new_d, perr_d, fe_d, busy_d;
  logic                 tick;
  logic                 fe_acc;
  logic                 perr_calc;

  assign tick   = (baud_q == '0);
  assign fe_acc = ferr_q | ~rxs;

  // Accumulated XOR covers data and parity bit; expected 1 for odd, 0 for even.
  always_comb begin
    perr_calc = 1'b0;
    if (PARITY == PARITY_ODD)       perr_calc = ~par_q;
    else if (PARITY == PARITY_EVEN) perr_calc = par_q;
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    ferr_d      = ferr_q;
    wait_high_d = wait_high_q;
    data_d      = data_out;
    new_d       = 1'b0;
    perr_d      = parity_err_out;
    fe_d        = frame_err_out;
    busy_d      = busy_out;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (rxs) wait_high_d = 1'b0;
        // After a break the same low level must not start a new frame.
        if (!rxs && !wait_high_q) begin
          state_d = START;
          baud_d  = BAUD_W'(HALF - 1);
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (!tick) baud_d = baud_q - BAUD_W'(1);
        else if (rxs) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = DATA;
          baud_d  = BAUD_W'(CLK_BAUD_RATIO - 1);
          bit_d   = '0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      DATA: begin
        if (!tick) baud_d = baud_q - BAUD_W'(1);
        else begin
          shreg_d = (shreg_q >> 1) | (DATA_SIZE'(rxs) << (DATA_SIZE - 1));
          par_d   = par_q ^ rxs;
          baud_d  = BAUD_W'(CLK_BAUD_RATIO - 1);
          if (bit_q == BIT_W'(DATA_SIZE - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (!tick) baud_d = baud_q - BAUD_W'(1);
        else begin
          par_d   = par_q ^ rxs;
          baud_d  = BAUD_W'(CLK_BAUD_RATIO - 1);
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) baud_d = baud_q - BAUD_W'(1);
        else if (bit_q == BIT_W'(STOP_BITS - 1)) begin
          // Return to IDLE at the stop-bit centre so a following start is not missed.
          state_d     = IDLE;
          new_d       = 1'b1;
          data_d      = shreg_q;
          perr_d      = perr_calc;
          fe_d        = fe_acc;
          busy_d      = 1'b0;
          wait_high_d = ~rxs;
          bit_d       = '0;
        end else begin
          ferr_d = fe_acc;
          bit_d  = bit_q + BIT_W'(1);
          baud_d = BAUD_W'(CLK_BAUD_RATIO - 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      baud_q         <= '0;
      bit_q          <= '0;
      shreg_q        <= '0;
      par_q          <= 1'b0;
      ferr_q         <= 1'b0;
      wait_high_q    <= 1'b0;
      data_out       <= '0;
      new_data_out   <= 1'b0;
      parity_err_out <= 1'b0;
      frame_err_out  <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      state_q        <= state_d;
      baud_q         <= baud_d;
      bit_q          <= bit_d;
      shreg_q        <= shreg_d;
      par_q          <= par_d;
      ferr_q         <= ferr_d;
      wait_high_q    <= wait_high_d;
      data_out       <= data_d;
      new_data_out   <= new_d;
      parity_err_out <= perr_d;
      frame_err_out  <= fe_d;
      busy_out       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench: three receiver configurations (8N1, 8E1, 8N2) checked by a pulse scoreboard.
module tb_uart_rx_framed;

  localparam int R    = 25;
  localparam int HALF = 12;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] d0, d1, d2;
  logic nd0, nd1, nd2, pe0, pe1, pe2, fe0, fe1, fe2, by0, by1, by2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_framed dut_def (
    .clk_in(clk), .rst_in(rst), .rx_in(rx0), .data_out(d0), .new_data_out(nd0),
    .parity_err_out(pe0), .frame_err_out(fe0), .busy_out(by0));

  uart_rx_framed #(.PARITY(2)) dut_par (
    .clk_in(clk), .rst_in(rst), .rx_in(rx1), .data_out(d1), .new_data_out(nd1),
    .parity_err_out(pe1), .frame_err_out(fe1), .busy_out(by1));

  uart_rx_framed #(.STOP_BITS(2)) dut_s2 (
    .clk_in(clk), .rst_in(rst), .rx_in(rx2), .data_out(d2), .new_data_out(nd2),
    .parity_err_out(pe2), .frame_err_out(fe2), .busy_out(by2));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         at;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int total = 0;
  int passed = 0;
  int npulse [3] = '{0, 0, 0};
  int last_at[3] = '{0, 0, 0};
  int prev_at[3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int sel, input logic [7:0] d, input logic pe, input logic fe, input int at);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.at = at;
    case (sel)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic on_pulse(input int sel, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    bit have;
    npulse[sel]++;
    prev_at[sel] = last_at[sel];
    last_at[sel] = cyc;
    case (sel)
      0: begin have = (q0.size() > 0); if (have) e = q0.pop_front(); end
      1: begin have = (q1.size() > 0); if (have) e = q1.pop_front(); end
      default: begin have = (q2.size() > 0); if (have) e = q2.pop_front(); end
    endcase
    check($sformatf("pulse_expected_dut%0d", sel), 32'(have), 32'd1);
    if (have) begin
      check($sformatf("data_dut%0d", sel), 32'(d), 32'(e.data));
      check($sformatf("perr_dut%0d", sel), 32'(pe), 32'(e.perr));
      check($sformatf("ferr_dut%0d", sel), 32'(fe), 32'(e.ferr));
      check($sformatf("pulse_cycle_dut%0d", sel), 32'(cyc), 32'(e.at));
    end
  endtask

  always @(negedge clk) if (nd0) on_pulse(0, d0, pe0, fe0);
  always @(negedge clk) if (nd1) on_pulse(1, d1, pe1, fe1);
  always @(negedge clk) if (nd2) on_pulse(2, d2, pe2, fe2);

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned (just after a posedge); returns aligned.
  task automatic drive_bits(input int sel, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      repeat (R) @(posedge clk);
      #1;
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic wait_cycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  function automatic logic [31:0] frame(input logic [7:0] d, input bit pen, input logic pb,
                                        input logic s0, input logic s1);
    logic [31:0] b;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = d;
    if (pen) begin b[9] = pb; b[10] = s0; b[11] = s1; end
    else     begin b[9] = s0; b[10] = s1; end
    return b;
  endfunction

  // Drive start edge in cycle c: t0 = c+SYNC, last stop sample t0+HALF+(8+P+S)*R, pulse one later.
  function automatic int pulse_at(input int c, input int p, input int s);
    return c + SYNC + HALF + (8 + p + s) * R + 1;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data", 32'(d0), 32'd0);
    check("reset_pulse", 32'(nd0), 32'd0);
    check("reset_perr", 32'(pe0), 32'd0);
    check("reset_ferr", 32'(fe0), 32'd0);
    check("reset_busy", 32'(by0), 32'd0);
    idle(40);
    check("no_start_after_reset", 32'(by0 | by1 | by2), 32'd0);

    // 8N1 frame 0xA5 with busy window
    align(); c = cyc;
    push(0, 8'hA5, 1'b0, 1'b0, pulse_at(c, 0, 1));
    fork
      drive_bits(0, frame(8'hA5, 0, 1'b0, 1'b1, 1'b1), 10);
      begin
        wait_cycle(c + SYNC);       check("busy_at_t0", 32'(by0), 32'd0);
        wait_cycle(c + SYNC + 1);   check("busy_at_t0p1", 32'(by0), 32'd1);
        wait_cycle(c + SYNC + 237); check("busy_at_t0p237", 32'(by0), 32'd1);
        wait_cycle(c + SYNC + 238); check("busy_at_t0p238", 32'(by0), 32'd0);
      end
    join
    idle(20);

    // 10-cycle glitch is rejected at t0+HALF
    align(); c = cyc;
    set_rx(0, 1'b0);
    idle(10);
    set_rx(0, 1'b1);
    wait_cycle(c + SYNC + HALF);     check("glitch_busy_at_reject", 32'(by0), 32'd1);
    wait_cycle(c + SYNC + HALF + 1); check("glitch_busy_dropped", 32'(by0), 32'd0);
    idle(300);
    check("glitch_no_pulse", 32'(npulse[0]), 32'd1);

    // Even parity: 0x07 has three ones, parity bit 0 is wrong, 1 is right
    align(); c = cyc;
    push(1, 8'h07, 1'b1, 1'b0, pulse_at(c, 1, 1));
    drive_bits(1, frame(8'h07, 1, 1'b0, 1'b1, 1'b1), 11);
    idle(30);
    c = cyc;
    push(1, 8'h07, 1'b0, 1'b0, pulse_at(c, 1, 1));
    drive_bits(1, frame(8'h07, 1, 1'b1, 1'b1, 1'b1), 11);
    idle(30);
    check("parity_pulses", 32'(npulse[1]), 32'd2);

    // Two stop bits: second stop low gives a framing error
    c = cyc;
    push(2, 8'h3C, 1'b0, 1'b1, pulse_at(c, 0, 2));
    drive_bits(2, frame(8'h3C, 0, 1'b0, 1'b1, 1'b0), 11);
    idle(30);

    // Break: 20 bit-times low, one pulse, no retrigger while low
    c = cyc;
    push(2, 8'h00, 1'b0, 1'b1, pulse_at(c, 0, 2));
    set_rx(2, 1'b0);
    idle(300);
    check("break_idle_busy", 32'(by2), 32'd0);
    idle(20 * R - 300);
    check("break_still_idle", 32'(by2), 32'd0);
    check("break_single_pulse", 32'(npulse[2]), 32'd2);
    set_rx(2, 1'b1);
    idle(50);
    check("break_no_new_frame", 32'(npulse[2]), 32'd2);
    c = cyc;
    push(2, 8'h81, 1'b0, 1'b0, pulse_at(c, 0, 2));
    drive_bits(2, frame(8'h81, 0, 1'b0, 1'b1, 1'b1), 11);
    idle(30);
    check("after_break_pulses", 32'(npulse[2]), 32'd3);

    // Back-to-back frames with no idle gap
    c = cyc;
    push(0, 8'h55, 1'b0, 1'b0, pulse_at(c, 0, 1));
    push(0, 8'hAA, 1'b0, 1'b0, pulse_at(c + 10 * R, 0, 1));
    drive_bits(0, frame(8'h55, 0, 1'b0, 1'b1, 1'b1), 10);
    drive_bits(0, frame(8'hAA, 0, 1'b0, 1'b1, 1'b1), 10);
    idle(30);
    check("b2b_pulses", 32'(npulse[0]), 32'd3);
    check("b2b_gap", 32'(last_at[0] - prev_at[0]), 32'(10 * R));

    // Reset during data bit 4; remaining bits of 0xF5 are high so nothing restarts
    align(); c = cyc;
    fork
      drive_bits(0, frame(8'hF5, 0, 1'b0, 1'b1, 1'b1), 10);
      begin
        wait_cycle(c + 5 * R + 10);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_data", 32'(d0), 32'd0);
        check("midreset_busy", 32'(by0), 32'd0);
        check("midreset_flags", 32'({pe0, fe0, nd0}), 32'd0);
      end
    join
    idle(300);
    check("midreset_no_pulse", 32'(npulse[0]), 32'd3);
    c = cyc;
    push(0, 8'h3F, 1'b0, 1'b0, pulse_at(c, 0, 1));
    drive_bits(0, frame(8'h3F, 0, 1'b0, 1'b1, 1'b1), 10);
    idle(50);
    check("after_reset_pulses", 32'(npulse[0]), 32'd4);

    check("queue0_drained", 32'(q0.size()), 32'd0);
    check("queue1_drained", 32'(q1.size()), 32'd0);
    check("queue2_drained", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
